vta_mem_arbiter: RTL and testbench

VTA_MEM_ARBITER -- requirements
Module: vta_mem_arbiter

---
 rtl/vta_mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_vta_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vta_mem_arbiter.sv
// Round-robin arbiter that funnels NUM_CH client memory ports onto a single
// DPI-style memory port, one burst transaction outstanding at a time.
module vta_mem_arbiter #(
    parameter  int NUM_CH    = 4,
    parameter  int LEN_BITS  = 8,
    parameter  int ADDR_BITS = 64,
    parameter  int DATA_BITS = 64,
    localparam int GNT_BITS  = $clog2(NUM_CH)
) (
    input  logic                          clock,
    input  logic                          reset,

    input  logic [NUM_CH-1:0]             cl_req_valid,
    output logic [NUM_CH-1:0]             cl_req_ready,
    input  logic [NUM_CH-1:0]             cl_req_opcode,
    input  logic [NUM_CH*LEN_BITS-1:0]    cl_req_len,
    input  logic [NUM_CH*ADDR_BITS-1:0]   cl_req_addr,

    input  logic [NUM_CH-1:0]             cl_wr_valid,
    output logic [NUM_CH-1:0]             cl_wr_ready,
    input  logic [NUM_CH*DATA_BITS-1:0]   cl_wr_bits,

    output logic [NUM_CH-1:0]             cl_rd_valid,
    input  logic [NUM_CH-1:0]             cl_rd_ready,
    output logic [DATA_BITS-1:0]          cl_rd_bits,

    output logic                          dpi_req_valid,
    output logic                          dpi_req_opcode,
    output logic [LEN_BITS-1:0]           dpi_req_len,
    output logic [ADDR_BITS-1:0]          dpi_req_addr,
    output logic                          dpi_wr_valid,
    output logic [DATA_BITS-1:0]          dpi_wr_bits,
    input  logic                          dpi_rd_valid,
    input  logic [DATA_BITS-1:0]          dpi_rd_bits,
    output logic                          dpi_rd_ready,

    output logic [GNT_BITS-1:0]           grant_id,
    output logic                          busy,
    output logic                          err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2,
        READ  = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [GNT_BITS-1:0]   last_grant_q;
    logic [GNT_BITS-1:0]   grant_q;
    logic                  opcode_q;
    logic [LEN_BITS-1:0]   len_q;
    logic [ADDR_BITS-1:0]  addr_q;
    logic [LEN_BITS-1:0]   cnt_q;
    logic                  err_q;

    logic [GNT_BITS-1:0]   winner;
    logic                  any_req;
    logic                  found;
    logic                  accept;
    logic                  wr_fire;
    logic                  rd_fire;
    logic                  last_beat;

    // Round-robin search starts one past the previous winner.
    // NOTE: every variable written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        any_req = |cl_req_valid;
        for (int k = 1; k <= NUM_CH; k++) begin
            if (!found && cl_req_valid[(int'(last_grant_q) + k) % NUM_CH]) begin
                found  = 1'b1;
                winner = GNT_BITS'((int'(last_grant_q) + k) % NUM_CH);
            end
        end
    end

    assign accept    = (state_q == IDLE) && any_req;
    assign wr_fire   = (state_q == WRITE) && cl_wr_valid[grant_q];
    assign rd_fire   = (state_q == READ) && dpi_rd_valid && cl_rd_ready[grant_q];
    assign last_beat = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = REQ;
            REQ:     state_d = opcode_q ? WRITE : READ;
            WRITE:   if (wr_fire && last_beat) state_d = IDLE;
            READ:    if (rd_fire && last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= GNT_BITS'(NUM_CH - 1);
            grant_q      <= '0;
            opcode_q     <= 1'b0;
            len_q        <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            if (accept) begin
                last_grant_q <= winner;
                grant_q      <= winner;
                opcode_q     <= cl_req_opcode[winner];
                len_q        <= cl_req_len[winner*LEN_BITS +: LEN_BITS];
                addr_q       <= cl_req_addr[winner*ADDR_BITS +: ADDR_BITS];
            end
            // The counter stops at zero, so a full-length burst never wraps.
            if (state_q == REQ)
                cnt_q <= len_q;
            else if ((wr_fire || rd_fire) && !last_beat)
                cnt_q <= cnt_q - 1'b1;
            if (dpi_rd_valid && (state_q != READ))
                err_q <= 1'b1;
        end
    end

    // Client-side handshakes are steered only to the granted channel; the
    // request-ready path is also masked by reset since it is purely combinational.
    always_comb begin
        cl_req_ready = '0;
        cl_wr_ready  = '0;
        cl_rd_valid  = '0;
        cl_rd_bits   = '0;
        dpi_req_valid = 1'b0;
        dpi_wr_valid = 1'b0;
        dpi_wr_bits  = '0;
        dpi_rd_ready = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req && reset)
                    cl_req_ready[winner] = 1'b1;
            end
            REQ: begin
                dpi_req_valid = 1'b1;
            end
            WRITE: begin
                cl_wr_ready[grant_q] = 1'b1;
                dpi_wr_valid         = cl_wr_valid[grant_q];
                dpi_wr_bits          = cl_wr_bits[grant_q*DATA_BITS +: DATA_BITS];
            end
            READ: begin
                cl_rd_valid[grant_q] = dpi_rd_valid;
                dpi_rd_ready         = cl_rd_ready[grant_q];
                cl_rd_bits           = dpi_rd_bits;
            end
            default: ;
        endcase
    end

    assign dpi_req_opcode = opcode_q;
    assign dpi_req_len    = len_q;
    assign dpi_req_addr   = addr_q;
    assign grant_id       = grant_q;
    assign busy           = (state_q != IDLE);
    assign err            = err_q;

endmodule

// File: tb/tb_vta_mem_arbiter.sv
// Directed-plus-random bench for vta_mem_arbiter: a transaction-level model
// predicts arbitration, beat counts, steering and the sticky error flag.
module tb_vta_mem_arbiter;

    localparam int N  = 4;
    localparam int LB = 8;
    localparam int AB = 64;
    localparam int DB = 64;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      cl_req_valid = '0;
    logic [N-1:0]      cl_req_ready;
    logic [N-1:0]      cl_req_opcode = '0;
    logic [N*LB-1:0]   cl_req_len = '0;
    logic [N*AB-1:0]   cl_req_addr = '0;
    logic [N-1:0]      cl_wr_valid = '0;
    logic [N-1:0]      cl_wr_ready;
    logic [N*DB-1:0]   cl_wr_bits = '0;
    logic [N-1:0]      cl_rd_valid;
    logic [N-1:0]      cl_rd_ready = '0;
    logic [DB-1:0]     cl_rd_bits;
    logic              dpi_req_valid;
    logic              dpi_req_opcode;
    logic [LB-1:0]     dpi_req_len;
    logic [AB-1:0]     dpi_req_addr;
    logic              dpi_wr_valid;
    logic [DB-1:0]     dpi_wr_bits;
    logic              dpi_rd_valid = 1'b0;
    logic [DB-1:0]     dpi_rd_bits = '0;
    logic              dpi_rd_ready;
    logic [1:0]        grant_id;
    logic              busy;
    logic              err;

    vta_mem_arbiter #(.NUM_CH(N), .LEN_BITS(LB), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
        .clock(clock), .reset(reset),
        .cl_req_valid(cl_req_valid), .cl_req_ready(cl_req_ready),
        .cl_req_opcode(cl_req_opcode), .cl_req_len(cl_req_len), .cl_req_addr(cl_req_addr),
        .cl_wr_valid(cl_wr_valid), .cl_wr_ready(cl_wr_ready), .cl_wr_bits(cl_wr_bits),
        .cl_rd_valid(cl_rd_valid), .cl_rd_ready(cl_rd_ready), .cl_rd_bits(cl_rd_bits),
        .dpi_req_valid(dpi_req_valid), .dpi_req_opcode(dpi_req_opcode),
        .dpi_req_len(dpi_req_len), .dpi_req_addr(dpi_req_addr),
        .dpi_wr_valid(dpi_wr_valid), .dpi_wr_bits(dpi_wr_bits),
        .dpi_rd_valid(dpi_rd_valid), .dpi_rd_bits(dpi_rd_bits), .dpi_rd_ready(dpi_rd_ready),
        .grant_id(grant_id), .busy(busy), .err(err)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model state: who was granted last, and whether an error was seen.
    int   model_last = N - 1;
    logic model_err  = 1'b0;

    logic [N-1:0]  op_f = '0;
    logic [LB-1:0] len_f [N];
    logic [AB-1:0] addr_f[N];
    logic [DB-1:0] wd    [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] mask, input int last);
        for (int k = 1; k <= N; k++)
            if (mask[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int w);
        logic [N-1:0] r;
        r = '0;
        r[w] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    task automatic drive_bus();
        cl_req_opcode = op_f;
        for (int c = 0; c < N; c++) begin
            cl_req_len[c*LB +: LB]  = len_f[c];
            cl_req_addr[c*AB +: AB] = addr_f[c];
            cl_wr_bits[c*DB +: DB]  = wd[c];
        end
    endtask

    task automatic rand_fields(input int maxlen);
        for (int c = 0; c < N; c++) begin
            op_f[c]   = 1'($urandom_range(1, 0));
            len_f[c]  = LB'($urandom_range(maxlen, 0));
            addr_f[c] = rand64();
            wd[c]     = rand64();
        end
    endtask

    task automatic model_reset();
        model_last = N - 1;
        model_err  = 1'b0;
    endtask

    // One complete transaction; called at posedge+1 with the DUT in IDLE.
    task automatic txn(input logic [N-1:0] mask, input int stall_pct,
                       input bit directed_rd, output int g);
        int  w;
        int  beats;
        int  cyc;
        int  nbeats;
        bit  v;
        bit  r;
        w = rr_pick(mask, model_last);
        cl_req_valid = mask;
        drive_bus();
        #1;
        check("idle_busy", busy, 0);
        check("req_ready", cl_req_ready, onehot(w));
        @(posedge clock); #1;
        model_last = w;
        nbeats = int'(len_f[w]) + 1;
        #1;
        check("req_valid", dpi_req_valid, 1);
        check("req_opcode", dpi_req_opcode, op_f[w]);
        check("req_len", dpi_req_len, len_f[w]);
        check("req_addr", dpi_req_addr, addr_f[w]);
        check("grant_id", grant_id, w);
        check("req_ready_busy", cl_req_ready, 0);
        g = int'(grant_id);
        @(posedge clock); #1;
        beats = 0;
        cyc   = 0;
        while (beats < nbeats && cyc < 3000) begin
            if (op_f[w]) begin
                v = ($urandom_range(99, 0) >= stall_pct);
                cl_wr_valid    = 4'($urandom);
                cl_wr_valid[w] = v;
                for (int c = 0; c < N; c++) wd[c] = rand64();
                drive_bus();
                #1;
                check("wr_busy", busy, 1);
                check("wr_req_strobe", dpi_req_valid, 0);
                check("wr_req_ready", cl_req_ready, 0);
                check("wr_ready", cl_wr_ready, onehot(w));
                check("wr_valid", dpi_wr_valid, v);
                if (v) check("wr_bits", dpi_wr_bits, wd[w]);
                if (v) beats++;
            end else begin
                v = directed_rd ? 1'b1 : ($urandom_range(99, 0) >= stall_pct);
                r = directed_rd ? (cyc != 1) : ($urandom_range(99, 0) >= stall_pct);
                dpi_rd_valid   = v;
                dpi_rd_bits    = rand64();
                cl_rd_ready    = 4'($urandom);
                cl_rd_ready[w] = r;
                #1;
                check("rd_busy", busy, 1);
                check("rd_req_ready", cl_req_ready, 0);
                check("rd_valid", cl_rd_valid, v ? onehot(w) : '0);
                check("rd_ready", dpi_rd_ready, r);
                check("rd_bits", cl_rd_bits, dpi_rd_bits);
                if (v && r) beats++;
            end
            cyc++;
            @(posedge clock); #1;
        end
        cl_req_valid = '0;
        cl_wr_valid  = '0;
        cl_rd_ready  = '0;
        dpi_rd_valid = 1'b0;
        #1;
        check("end_idle", busy, 0);
        check("end_wr_valid", dpi_wr_valid, 0);
        check("end_err", err, model_err);
    endtask

    int g;
    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rand_fields(7);
        drive_bus();

        // Reset state, with requests and a stray read beat pending.
        cl_req_valid = '1;
        cl_wr_valid  = '1;
        cl_rd_ready  = '1;
        dpi_rd_valid = 1'b1;
        #12;
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
        check("rst_err", err, 0);
        check("rst_req_ready", cl_req_ready, 0);
        check("rst_wr_ready", cl_wr_ready, 0);
        check("rst_rd_valid", cl_rd_valid, 0);
        check("rst_dpi_req", dpi_req_valid, 0);
        check("rst_dpi_wr", dpi_wr_valid, 0);
        check("rst_dpi_rd_ready", dpi_rd_ready, 0);
        check("rst_dpi_len", dpi_req_len, 0);
        cl_req_valid = '0;
        cl_wr_valid  = '0;
        cl_rd_ready  = '0;
        dpi_rd_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;

        // All channels requesting continuously, single-beat writes.
        op_f = '1;
        for (int c = 0; c < N; c++) len_f[c] = '0;
        for (int t = 0; t < 5; t++) begin
            txn(4'hF, 0, 1'b0, g);
            check("rr_order", g, order[t]);
        end

        // Ch0 write of 4 beats, write-valid always high.
        rand_fields(0);
        op_f[0]  = 1'b1;
        len_f[0] = 8'd3;
        txn(4'b0001, 0, 1'b0, g);

        // Ch2 read of 2 beats with a one-cycle client stall.
        op_f[2]  = 1'b0;
        len_f[2] = 8'd1;
        txn(4'b0100, 0, 1'b1, g);

        // Stray read beat in IDLE: dropped, sets the sticky error.
        dpi_rd_valid = 1'b1;
        dpi_rd_bits  = rand64();
        cl_rd_ready  = '1;
        #1;
        check("stray_rd_valid", cl_rd_valid, 0);
        check("stray_rd_ready", dpi_rd_ready, 0);
        check("stray_rd_bits", cl_rd_bits, 0);
        @(posedge clock); #1;
        dpi_rd_valid = 1'b0;
        cl_rd_ready  = '0;
        model_err    = 1'b1;
        #1;
        check("err_set", err, 1);
        @(posedge clock); #1;

        // Random mixed traffic with stalls; err must stay set throughout.
        for (int t = 0; t < 15; t++) begin
            rand_fields(6);
            txn(4'($urandom_range(15, 1)), 30, 1'b0, g);
        end

        // Maximum-length write.
        rand_fields(0);
        op_f[3]  = 1'b1;
        len_f[3] = 8'd255;
        txn(4'b1000, 0, 1'b0, g);

        // Reset during beat 2 of a 6-beat write on ch1.
        rand_fields(0);
        op_f[1]  = 1'b1;
        len_f[1] = 8'd5;
        cl_req_valid = 4'b0010;
        cl_wr_valid  = '1;
        drive_bus();
        #1;
        check("abort_accept", cl_req_ready, onehot(rr_pick(4'b0010, model_last)));
        @(posedge clock); #1;
        cl_req_valid = '0;
        @(posedge clock); #1;
        check("abort_beat0", dpi_wr_valid, 1);
        @(posedge clock); #1;
        check("abort_beat1", dpi_wr_valid, 1);
        @(posedge clock); #1;
        check("abort_beat2", dpi_wr_valid, 1);
        reset = 1'b0;
        model_reset();
        #1;
        check("abort_wr_valid", dpi_wr_valid, 0);
        check("abort_wr_ready", cl_wr_ready, 0);
        check("abort_busy", busy, 0);
        check("abort_grant", grant_id, 0);
        check("abort_err", err, 0);
        check("abort_req_valid", dpi_req_valid, 0);
        @(posedge clock); #1;
        check("abort_hold", dpi_wr_valid, 0);
        reset = 1'b1;
        #1;
        check("post_rst_no_replay", dpi_wr_valid, 0);
        @(posedge clock); #1;
        check("post_rst_idle", busy, 0);
        check("post_rst_no_strobe", dpi_req_valid, 0);
        cl_wr_valid = '0;
        rand_fields(3);
        txn(4'hF, 0, 1'b0, g);
        check("post_rst_ch0_first", g, 0);

        @(posedge clock); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
